reg_bank_mp: RTL and testbench

Parametrised multi-port register file and successor to the single-write, two-read register bank. Provides NR asynchronous read ports, two synchronous write ports with fixed priority, optional same-cycle write-to-read bypass, an optional hardwired zero register, and a per-register pending (busy) scoreboard for the pipeline's hazard logic. Sits between decode (reads, issue marking) and writeback (two retire lanes) in the core datapath.

---
 rtl/reg_bank_mp_if.sv | 37 +++
 rtl/reg_bank_mp.sv | 119 +++++++++++
 tb/tb_reg_bank_mp.sv | 135 +++++++++++++
 3 files changed

// File: rtl/reg_bank_mp_if.sv
// reg_bank_mp_if: bundles the register-file read, write-back and issue signals.
//   rd_addr  : NR packed read addresses, port i at [i*AW +: AW]
//   rd_data  : NR packed read data, port i at [i*W +: W]
//   rd_busy  : per-port pending flag of the addressed register
//   wr0_*    : write lane 0 (lower priority)
//   wr1_*    : write lane 1 (higher priority)
//   iss_*    : mark a destination register as pending
// master = pipeline side (decode/writeback), slave = register file.
interface reg_bank_mp_if #(
    parameter int W  = 32,
    parameter int AW = 5,
    parameter int NR = 2
);
    logic [NR*AW-1:0] rd_addr;
    logic [NR*W-1:0]  rd_data;
    logic [NR-1:0]    rd_busy;
    logic             wr0_en;
    logic [AW-1:0]    wr0_addr;
    logic [W-1:0]     wr0_data;
    logic             wr1_en;
    logic [AW-1:0]    wr1_addr;
    logic [W-1:0]     wr1_data;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, iss_en, iss_addr,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, iss_en, iss_addr,
        output rd_data, rd_busy
    );
endinterface

// File: rtl/reg_bank_mp.sv
// reg_bank_mp: multi-port register file with a per-register pending scoreboard.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (clears registers and busy bits)
//   bus   : reg_bank_mp_if slave -- NR async read ports, two write lanes
//           (lane 1 wins on address collision), issue port for busy marking.
// Parameters: W data width, AW address width (2**AW registers), NR read
// ports, ZERO_REG hardwires r0 to zero/not-busy, BYPASS forwards same-cycle
// write data and busy-clear onto the read ports.

// One read port: picks zero / lane-1 forward / lane-0 forward / array value.
module reg_bank_mp_rdport #(
    parameter int W        = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  arr_data,
    input  logic          arr_busy,
    input  logic          wr0_en,
    input  logic [AW-1:0] wr0_addr,
    input  logic [W-1:0]  wr0_data,
    input  logic          wr1_en,
    input  logic [AW-1:0] wr1_addr,
    input  logic [W-1:0]  wr1_data,
    output logic [W-1:0]  data,
    output logic          busy
);
    logic is_zero, hit0, hit1;

    // Forwarding is suppressed while in reset: those writes never commit.
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign hit1    = (BYPASS != 0) && rst_n && wr1_en && (wr1_addr == addr);
    assign hit0    = (BYPASS != 0) && rst_n && wr0_en && (wr0_addr == addr);

    always_comb begin
        data = arr_data;
        busy = arr_busy;
        if (is_zero) begin
            data = '0;
            busy = 1'b0;
        end else if (hit1) begin
            data = wr1_data;
            busy = 1'b0;
        end else if (hit0) begin
            data = wr0_data;
            busy = 1'b0;
        end
    end
endmodule

module reg_bank_mp #(
    parameter int W        = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_bank_mp_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0][W-1:0] regs;
    logic [DEPTH-1:0]        busy;
    logic [NR-1:0][AW-1:0]   ra;
    logic [NR-1:0][W-1:0]    rd;
    logic [NR-1:0]           rb;
    logic                    wr0_ok, wr1_ok, iss_ok;

    assign wr0_ok = bus.wr0_en && !((ZERO_REG != 0) && (bus.wr0_addr == '0));
    assign wr1_ok = bus.wr1_en && !((ZERO_REG != 0) && (bus.wr1_addr == '0));
    assign iss_ok = bus.iss_en && !((ZERO_REG != 0) && (bus.iss_addr == '0));

    // Statement order encodes priority: lane 1 overrides lane 0, and an
    // issue overrides a same-address busy clear (new producer outstanding).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '0;
            busy <= '0;
        end else begin
            if (wr0_ok) begin
                regs[bus.wr0_addr] <= bus.wr0_data;
                busy[bus.wr0_addr] <= 1'b0;
            end
            if (wr1_ok) begin
                regs[bus.wr1_addr] <= bus.wr1_data;
                busy[bus.wr1_addr] <= 1'b0;
            end
            if (iss_ok)
                busy[bus.iss_addr] <= 1'b1;
        end
    end

    assign ra          = bus.rd_addr;
    assign bus.rd_data = rd;
    assign bus.rd_busy = rb;

    for (genvar i = 0; i < NR; i++) begin : g_rd
        reg_bank_mp_rdport #(
            .W(W), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_port (
            .rst_n    (rst_n),
            .addr     (ra[i]),
            .arr_data (regs[ra[i]]),
            .arr_busy (busy[ra[i]]),
            .wr0_en   (bus.wr0_en),
            .wr0_addr (bus.wr0_addr),
            .wr0_data (bus.wr0_data),
            .wr1_en   (bus.wr1_en),
            .wr1_addr (bus.wr1_addr),
            .wr1_data (bus.wr1_data),
            .data     (rd[i]),
            .busy     (rb[i])
        );
    end
endmodule

// File: tb/tb_reg_bank_mp.sv
// tb_reg_bank_mp: directed table-driven bench. Two instances share stimulus:
// dut_b (BYPASS=1) and dut_n (BYPASS=0); both with ZERO_REG=1, NR=2.
module tb_reg_bank_mp;
    logic        clk;
    logic        rst_n;
    logic [4:0]  ra0, ra1;
    logic        wr0_en, wr1_en, iss_en;
    logic [4:0]  wr0_addr, wr1_addr, iss_addr;
    logic [31:0] wr0_data, wr1_data;
    int          n_pass = 0;
    int          n_tot  = 0;

    reg_bank_mp_if #(.W(32), .AW(5), .NR(2)) bi ();
    reg_bank_mp_if #(.W(32), .AW(5), .NR(2)) ni ();

    assign bi.rd_addr = {ra1, ra0};
    assign bi.wr0_en = wr0_en;   assign bi.wr0_addr = wr0_addr; assign bi.wr0_data = wr0_data;
    assign bi.wr1_en = wr1_en;   assign bi.wr1_addr = wr1_addr; assign bi.wr1_data = wr1_data;
    assign bi.iss_en = iss_en;   assign bi.iss_addr = iss_addr;
    assign ni.rd_addr = {ra1, ra0};
    assign ni.wr0_en = wr0_en;   assign ni.wr0_addr = wr0_addr; assign ni.wr0_data = wr0_data;
    assign ni.wr1_en = wr1_en;   assign ni.wr1_addr = wr1_addr; assign ni.wr1_data = wr1_data;
    assign ni.iss_en = iss_en;   assign ni.iss_addr = iss_addr;

    reg_bank_mp #(.W(32), .AW(5), .NR(2), .ZERO_REG(1), .BYPASS(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bi));
    reg_bank_mp #(.W(32), .AW(5), .NR(2), .ZERO_REG(1), .BYPASS(0))
        dut_n (.clk(clk), .rst_n(rst_n), .bus(ni));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        w0e; logic [4:0] w0a; logic [31:0] w0d;
        logic        w1e; logic [4:0] w1a; logic [31:0] w1d;
        logic        ie;  logic [4:0] ia;
        logic [4:0]  ra0; logic [4:0] ra1;
        logic [31:0] ed0; logic [31:0] ed1; logic eb0; logic eb1;  // BYPASS=1
        logic [31:0] nd0; logic nb0;                               // BYPASS=0, port 0
    } vec_t;

    vec_t tv [21];

    function automatic vec_t mk(
        input logic rst,
        input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
        input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
        input logic ie,  input logic [4:0] ia,
        input logic [4:0] a0, input logic [4:0] a1,
        input logic [31:0] ed0, input logic [31:0] ed1, input logic eb0, input logic eb1,
        input logic [31:0] nd0, input logic nb0);
        vec_t v;
        v.rst = rst; v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d; v.ie = ie; v.ia = ia;
        v.ra0 = a0; v.ra1 = a1; v.ed0 = ed0; v.ed1 = ed1; v.eb0 = eb0; v.eb1 = eb1;
        v.nd0 = nd0; v.nb0 = nb0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        rst_n = v.rst;
        wr0_en = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
        wr1_en = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
        iss_en = v.ie;  iss_addr = v.ia;
        ra0 = v.ra0;    ra1 = v.ra1;
        @(negedge clk);
        chk($sformatf("v%0d b.d0", idx), bi.rd_data[31:0],  v.ed0);
        chk($sformatf("v%0d b.d1", idx), bi.rd_data[63:32], v.ed1);
        chk($sformatf("v%0d b.b0", idx), {31'd0, bi.rd_busy[0]}, {31'd0, v.eb0});
        chk($sformatf("v%0d b.b1", idx), {31'd0, bi.rd_busy[1]}, {31'd0, v.eb1});
        chk($sformatf("v%0d n.d0", idx), ni.rd_data[31:0],  v.nd0);
        chk($sformatf("v%0d n.b0", idx), {31'd0, ni.rd_busy[0]}, {31'd0, v.nb0});
    endtask

    initial begin
        //             rst w0e w0a w0d           w1e w1a w1d           ie ia  ra0 ra1 ed0           ed1           eb0 eb1 nd0           nb0
        tv[0]  = mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0,  5, 0, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0,        0);
        tv[1]  = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0);
        tv[2]  = mk(1, 1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 0,  7, 5, 32'h22222222, 32'hDEADBEEF, 0, 0, 32'h0,        0);
        tv[3]  = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  7, 7, 32'h22222222, 32'h22222222, 0, 0, 32'h22222222, 0);
        tv[4]  = mk(1, 1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        1, 0,  0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0);
        tv[5]  = mk(1, 0, 0, 32'h0,        1, 0, 32'hFFFFFFFF, 0, 0,  0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0);
        tv[6]  = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0);
        tv[7]  = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 9,  9, 9, 32'h0,        32'h0,        0, 0, 32'h0,        0);
        tv[8]  = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  9, 0, 32'h0,        32'h0,        1, 0, 32'h0,        1);
        tv[9]  = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  9, 9, 32'h0,        32'h0,        1, 1, 32'h0,        1);
        tv[10] = mk(1, 0, 0, 32'h0,        1, 9, 32'h00000099, 0, 0,  9, 9, 32'h00000099, 32'h00000099, 0, 0, 32'h0,        1);
        tv[11] = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  9, 9, 32'h00000099, 32'h00000099, 0, 0, 32'h00000099, 0);
        tv[12] = mk(1, 1, 9, 32'h00001234, 0, 0, 32'h0,        1, 9,  9, 9, 32'h00001234, 32'h00001234, 0, 0, 32'h00000099, 0);
        tv[13] = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  9, 9, 32'h00001234, 32'h00001234, 1, 1, 32'h00001234, 1);
        tv[14] = mk(1, 0, 0, 32'h0,        1, 3, 32'hA5A5A5A5, 1, 4,  3, 4, 32'hA5A5A5A5, 32'h0,        0, 0, 32'h0,        0);
        tv[15] = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  3, 4, 32'hA5A5A5A5, 32'h0,        0, 1, 32'hA5A5A5A5, 0);
        // reset cycle with concurrent writes/issue: no forwarding, no busy clear
        tv[16] = mk(0, 1, 4, 32'h44444444, 1, 3, 32'h77777777, 1, 5,  3, 4, 32'hA5A5A5A5, 32'h0,        0, 1, 32'hA5A5A5A5, 0);
        tv[17] = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  3, 4, 32'h0,        32'h0,        0, 0, 32'h0,        0);
        tv[18] = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  5, 9, 32'h0,        32'h0,        0, 0, 32'h0,        0);
        tv[19] = mk(1, 1, 10, 32'hAAAA0000, 1, 11, 32'hBBBB0000, 0, 0, 10, 11, 32'hAAAA0000, 32'hBBBB0000, 0, 0, 32'h0,      0);
        tv[20] = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 10, 11, 32'hAAAA0000, 32'hBBBB0000, 0, 0, 32'hAAAA0000, 0);

        rst_n = 1'b0;
        wr0_en = 0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 0; wr1_addr = '0; wr1_data = '0;
        iss_en = 0; iss_addr = '0; ra0 = '0; ra1 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Post-reset scan of every address on both ports.
        for (int a = 0; a < 32; a++) begin
            ra0 = 5'(a);
            ra1 = 5'(31 - a);
            @(negedge clk);
            chk($sformatf("rst b.d0 a%0d", a), bi.rd_data[31:0],  32'h0);
            chk($sformatf("rst b.d1 a%0d", a), bi.rd_data[63:32], 32'h0);
            chk($sformatf("rst b.busy a%0d", a), {30'd0, bi.rd_busy}, 32'h0);
            chk($sformatf("rst n.d0 a%0d", a), ni.rd_data[31:0],  32'h0);
            chk($sformatf("rst n.busy a%0d", a), {30'd0, ni.rd_busy}, 32'h0);
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 21; i++) apply(tv[i], i);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
